// File: rtl/iic_regfile_slave_if.sv
// I2C target-side bus bundle.
//   SCL, SDA_recv : synchronised line levels
//   start, stop   : 1-clk condition pulses from the SCL/SDA detector
//   edge_scl      : 1-clk pulse on any SCL transition (SCL already new level)
//   grab_SDA      : target drives SDA when 1
//   SDA_drive     : SDA value while grab_SDA=1
interface iic_regfile_slave_if;
   logic SCL;
   logic SDA_recv;
   logic start;
   logic stop;
   logic edge_scl;
   logic grab_SDA;
   logic SDA_drive;

   modport master (output SCL, SDA_recv, start, stop, edge_scl,
                   input  grab_SDA, SDA_drive);
   modport slave  (input  SCL, SDA_recv, start, stop, edge_scl,
                   output grab_SDA, SDA_drive);
endinterface

// File: rtl/iic_regfile_slave.sv
// I2C target with a NUM_REGS x 8-bit register file and auto-incrementing
// register pointer. First write byte after the address sets the pointer,
// later bytes are written to regs[ptr++]; reads stream regs[ptr++] until the
// master NACKs.
//   clk, reset : system clock, async active-high reset
//   bus        : I2C line levels, condition pulses, open-drain SDA control
//   regs_flat  : register file, reg i at [8i+7:8i]
//   wr_pulse   : 1-clk pulse when a register is written, wr_idx = its index
//   busy       : high from address ACK until STOP/START
module iic_regfile_slave #(
   parameter logic [6:0] ADDRESS   = 7'h45,
   parameter int         NUM_REGS  = 4,
   parameter logic [7:0] RESET_VAL = 8'h81,
   localparam int        PTR_W     = $clog2(NUM_REGS)
) (
   input  logic                    clk,
   input  logic                    reset,
   iic_regfile_slave_if.slave      bus,
   output logic [NUM_REGS*8-1:0]   regs_flat,
   output logic                    wr_pulse,
   output logic [PTR_W-1:0]        wr_idx,
   output logic                    busy
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ACK, PTR_RX, WR_RX, RD_TX, RD_ACK, WAIT_STOP
   } state_t;

   localparam logic [8:0]       NUM_REGS_C = 9'(NUM_REGS);
   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REGS - 1);

   state_t           state, state_n;
   logic [7:0]       sr, sr_n;
   logic [2:0]       bc, bc_n;
   logic [PTR_W-1:0] ptr, ptr_n;
   logic             rw, rw_n;
   // byte complete on the 8th rise, ACK to be driven on the following fall
   logic             pend, pend_n;
   // the ACK in progress belongs to the address byte
   logic             addr_ack, addr_ack_n;
   logic             grab_n, drive_n;
   logic             wr_pulse_n;
   logic [PTR_W-1:0] wr_idx_n;
   logic             busy_n;
   logic             we;

   logic [7:0]       regs [NUM_REGS];

   logic             rise, fall;
   logic [7:0]       sh;
   logic [7:0]       rd_byte;
   logic [PTR_W-1:0] ptr_inc;

   assign rise    = bus.edge_scl &  bus.SCL;
   assign fall    = bus.edge_scl & ~bus.SCL;
   assign sh      = {sr[6:0], bus.SDA_recv};
   assign rd_byte = regs[ptr];
   assign ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) regs_flat[i*8 +: 8] = regs[i];
   end

   always_comb begin
      state_n    = state;
      sr_n       = sr;
      bc_n       = bc;
      ptr_n      = ptr;
      rw_n       = rw;
      pend_n     = pend;
      addr_ack_n = addr_ack;
      grab_n     = bus.grab_SDA;
      drive_n    = bus.SDA_drive;
      wr_pulse_n = 1'b0;
      wr_idx_n   = wr_idx;
      busy_n     = busy;
      we         = 1'b0;

      if (bus.stop) begin
         state_n = IDLE;
         grab_n  = 1'b0;
         busy_n  = 1'b0;
         pend_n  = 1'b0;
      end else if (bus.start) begin
         // ptr survives so a repeated START can read from the written pointer
         state_n = ADDR;
         bc_n    = '0;
         grab_n  = 1'b0;
         busy_n  = 1'b0;
         pend_n  = 1'b0;
      end else begin
         case (state)
            IDLE: ;

            ADDR: begin
               if (rise && !pend) begin
                  sr_n = sh;
                  bc_n = bc + 3'd1;
                  if (bc == 3'd7) begin
                     if (sh[7:1] == ADDRESS) begin
                        rw_n   = sh[0];
                        pend_n = 1'b1;
                     end else begin
                        state_n = WAIT_STOP;
                     end
                  end
               end else if (fall && pend) begin
                  state_n    = ACK;
                  grab_n     = 1'b1;
                  drive_n    = 1'b0;
                  busy_n     = 1'b1;
                  addr_ack_n = 1'b1;
                  pend_n     = 1'b0;
               end
            end

            ACK: begin
               if (fall) begin
                  grab_n     = 1'b0;
                  bc_n       = '0;
                  addr_ack_n = 1'b0;
                  if (rw) begin
                     // snapshot the byte so later writes cannot tear it
                     state_n = RD_TX;
                     sr_n    = rd_byte;
                     grab_n  = 1'b1;
                     drive_n = rd_byte[7];
                  end else if (addr_ack) begin
                     state_n = PTR_RX;
                  end else begin
                     state_n = WR_RX;
                  end
               end
            end

            PTR_RX: begin
               if (rise && !pend) begin
                  sr_n = sh;
                  bc_n = bc + 3'd1;
                  if (bc == 3'd7) begin
                     if ({1'b0, sh} < NUM_REGS_C) begin
                        ptr_n  = sh[PTR_W-1:0];
                        pend_n = 1'b1;
                     end else begin
                        state_n = WAIT_STOP;
                     end
                  end
               end else if (fall && pend) begin
                  state_n = ACK;
                  grab_n  = 1'b1;
                  drive_n = 1'b0;
                  pend_n  = 1'b0;
               end
            end

            WR_RX: begin
               if (rise && !pend) begin
                  sr_n = sh;
                  bc_n = bc + 3'd1;
                  if (bc == 3'd7) begin
                     we         = 1'b1;
                     wr_pulse_n = 1'b1;
                     wr_idx_n   = ptr;
                     ptr_n      = ptr_inc;
                     pend_n     = 1'b1;
                  end
               end else if (fall && pend) begin
                  state_n = ACK;
                  grab_n  = 1'b1;
                  drive_n = 1'b0;
                  pend_n  = 1'b0;
               end
            end

            RD_TX: begin
               if (fall) begin
                  if (bc == 3'd7) begin
                     grab_n  = 1'b0;
                     ptr_n   = ptr_inc;
                     bc_n    = '0;
                     state_n = RD_ACK;
                  end else begin
                     sr_n    = {sr[6:0], 1'b0};
                     drive_n = sr[6];
                     bc_n    = bc + 3'd1;
                  end
               end
            end

            RD_ACK: begin
               if (rise) begin
                  if (bus.SDA_recv) state_n = WAIT_STOP;
                  else              pend_n  = 1'b1;
               end else if (fall && pend) begin
                  pend_n  = 1'b0;
                  bc_n    = '0;
                  state_n = RD_TX;
                  sr_n    = rd_byte;
                  grab_n  = 1'b1;
                  drive_n = rd_byte[7];
               end
            end

            WAIT_STOP: grab_n = 1'b0;

            default: begin
               state_n = IDLE;
               grab_n  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         sr            <= '0;
         bc            <= '0;
         ptr           <= '0;
         rw            <= 1'b0;
         pend          <= 1'b0;
         addr_ack      <= 1'b0;
         bus.grab_SDA  <= 1'b0;
         bus.SDA_drive <= 1'b1;
         wr_pulse      <= 1'b0;
         wr_idx        <= '0;
         busy          <= 1'b0;
      end else begin
         state         <= state_n;
         sr            <= sr_n;
         bc            <= bc_n;
         ptr           <= ptr_n;
         rw            <= rw_n;
         pend          <= pend_n;
         addr_ack      <= addr_ack_n;
         bus.grab_SDA  <= grab_n;
         bus.SDA_drive <= drive_n;
         wr_pulse      <= wr_pulse_n;
         wr_idx        <= wr_idx_n;
         busy          <= busy_n;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      end else if (we) begin
         regs[ptr] <= sh;
      end
   end

endmodule

// File: tb/tb_iic_regfile_slave.sv
// Bench for iic_regfile_slave: bit-level I2C master model, scoreboard queues
// for ACK bits, read bytes and register writes.
module tb_iic_regfile_slave;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   iic_regfile_slave_if bus();

   logic        m_sda;
   logic [31:0] regs_flat;
   logic        wr_pulse;
   logic [1:0]  wr_idx;
   logic        busy;

   // open-drain wired-AND of master and target
   assign bus.SDA_recv = m_sda & (~bus.grab_SDA | bus.SDA_drive);

   iic_regfile_slave dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .regs_flat (regs_flat),
      .wr_pulse  (wr_pulse),
      .wr_idx    (wr_idx),
      .busy      (busy)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   int          wr_cnt = 0;
   logic        grab_seen, busy_seen;
   logic [31:0] exp_regs;
   logic [9:0]  wr_q[$];
   logic        ack_q[$];
   logic [7:0]  rd_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [9:0] e;
      if (bus.grab_SDA === 1'b1) grab_seen = 1'b1;
      if (busy === 1'b1) busy_seen = 1'b1;
      if (wr_pulse === 1'b1) begin
         wr_cnt++;
         if (wr_q.size() == 0) begin
            chk("wr_unexp", 32'(wr_pulse), 32'd0);
         end else begin
            e = wr_q.pop_front();
            chk("wr_idx", 32'(wr_idx), 32'(e[9:8]));
            chk("wr_data", 32'(regs_flat[wr_idx*8 +: 8]), 32'(e[7:0]));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scl_to(input logic v);
      bus.SCL      = v;
      bus.edge_scl = 1'b1;
      tick(1);
      bus.edge_scl = 1'b0;
      tick(4);
   endtask

   // expects SCL high
   task automatic do_start();
      m_sda     = 1'b0;
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(3);
      scl_to(1'b0);
   endtask

   // expects SCL low
   task automatic do_rstart();
      m_sda = 1'b1;
      tick(1);
      scl_to(1'b1);
      do_start();
   endtask

   task automatic do_stop();
      m_sda = 1'b0;
      tick(1);
      scl_to(1'b1);
      bus.stop = 1'b1;
      tick(1);
      bus.stop = 1'b0;
      m_sda    = 1'b1;
      tick(3);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic exp_ack);
      logic obs, e;
      ack_q.push_back(exp_ack);
      for (int i = 7; i >= 0; i--) begin
         m_sda = b[i];
         tick(1);
         scl_to(1'b1);
         scl_to(1'b0);
      end
      m_sda = 1'b1;
      tick(1);
      scl_to(1'b1);
      obs = bus.SDA_recv;
      scl_to(1'b0);
      e = ack_q.pop_front();
      chk("ack", 32'(obs), 32'(e));
   endtask

   task automatic recv_byte(input logic [7:0] exp, input logic nack);
      logic [7:0] v, e;
      rd_q.push_back(exp);
      m_sda = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         scl_to(1'b1);
         v[i] = bus.SDA_recv;
         scl_to(1'b0);
      end
      m_sda = nack;
      tick(1);
      scl_to(1'b1);
      scl_to(1'b0);
      m_sda = 1'b1;
      e = rd_q.pop_front();
      chk("rd_byte", 32'(v), 32'(e));
   endtask

   task automatic wr_byte(input logic [7:0] b, input logic [1:0] idx);
      wr_q.push_back({idx, b});
      exp_regs[idx*8 +: 8] = b;
      send_byte(b, 1'b0);
   endtask

   task automatic rd_reg(input logic [1:0] idx, input logic nack);
      recv_byte(exp_regs[idx*8 +: 8], nack);
   endtask

   initial begin
      reset        = 1'b1;
      bus.SCL      = 1'b1;
      bus.edge_scl = 1'b0;
      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      m_sda        = 1'b1;
      exp_regs     = {4{8'h81}};
      grab_seen    = 1'b0;
      busy_seen    = 1'b0;
      tick(3);
      chk("rst_grab", 32'(bus.grab_SDA), 32'd0);
      chk("rst_drive", 32'(bus.SDA_drive), 32'd1);
      chk("rst_regs", regs_flat, exp_regs);
      chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
      chk("rst_wr_idx", 32'(wr_idx), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick(2);

      // write burst, pointer 1
      do_start();
      send_byte(8'h8A, 1'b0);
      send_byte(8'h01, 1'b0);
      wr_byte(8'hA5, 2'd1);
      wr_byte(8'h3C, 2'd2);
      chk("wb_busy", 32'(busy), 32'd1);
      do_stop();
      chk("wb_busy_off", 32'(busy), 32'd0);
      chk("wb_grab_off", 32'(bus.grab_SDA), 32'd0);
      chk("wb_regs", regs_flat, exp_regs);

      // pointer 3, repeated START, read two with wrap
      do_start();
      send_byte(8'h8A, 1'b0);
      send_byte(8'h03, 1'b0);
      do_rstart();
      send_byte(8'h8B, 1'b0);
      rd_reg(2'd3, 1'b0);
      rd_reg(2'd0, 1'b1);
      do_stop();
      // ptr now 1
      do_start();
      send_byte(8'h8B, 1'b0);
      rd_reg(2'd1, 1'b1);
      do_stop();

      // address miss
      grab_seen = 1'b0;
      busy_seen = 1'b0;
      do_start();
      send_byte(8'h90, 1'b1);
      send_byte(8'h55, 1'b1);
      do_stop();
      chk("miss_grab", 32'(grab_seen), 32'd0);
      chk("miss_busy", 32'(busy_seen), 32'd0);
      chk("miss_regs", regs_flat, exp_regs);

      // bad pointer, ptr stays 2
      do_start();
      send_byte(8'h8A, 1'b0);
      send_byte(8'h07, 1'b1);
      send_byte(8'h11, 1'b1);
      do_stop();
      chk("badptr_regs", regs_flat, exp_regs);
      do_start();
      send_byte(8'h8B, 1'b0);
      rd_reg(2'd2, 1'b1);
      do_stop();

      // write across the pointer wrap
      do_start();
      send_byte(8'h8A, 1'b0);
      send_byte(8'h03, 1'b0);
      wr_byte(8'h11, 2'd3);
      wr_byte(8'h22, 2'd0);
      do_stop();
      chk("wrap_regs", regs_flat, exp_regs);

      // STOP partway through a data byte
      do_start();
      send_byte(8'h8A, 1'b0);
      send_byte(8'h01, 1'b0);
      for (int i = 0; i < 4; i++) begin
         m_sda = 1'b1;
         tick(1);
         scl_to(1'b1);
         scl_to(1'b0);
      end
      do_stop();
      chk("abort_grab", 32'(bus.grab_SDA), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_regs", regs_flat, exp_regs);

      // async reset while transmitting regs[1]=A5 (bit7 = 1 on the bus)
      do_start();
      send_byte(8'h8B, 1'b0);
      for (int i = 0; i < 3; i++) begin
         scl_to(1'b1);
         scl_to(1'b0);
      end
      chk("rd_grab", 32'(bus.grab_SDA), 32'd1);
      @(negedge clk);
      #2;
      reset = 1'b1;
      exp_regs = {4{8'h81}};
      #1;
      chk("arst_grab", 32'(bus.grab_SDA), 32'd0);
      chk("arst_regs", regs_flat, exp_regs);
      chk("arst_busy", 32'(busy), 32'd0);
      bus.SCL = 1'b1;
      m_sda   = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(2);

      // alive after reset
      do_start();
      send_byte(8'h8A, 1'b0);
      send_byte(8'h00, 1'b0);
      wr_byte(8'h5A, 2'd0);
      do_stop();
      chk("post_regs", regs_flat, exp_regs);
      do_start();
      send_byte(8'h8A, 1'b0);
      send_byte(8'h00, 1'b0);
      do_rstart();
      send_byte(8'h8B, 1'b0);
      rd_reg(2'd0, 1'b0);
      rd_reg(2'd1, 1'b1);
      do_stop();

      tick(2);
      chk("wr_cnt", 32'(wr_cnt), 32'd5);
      chk("wr_q_left", 32'(wr_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
